qdr_user_app_responder: RTL
===========================

Name: qdr_user_app_responder

Overview:
- Synthesizable stand-in for the QDR MIG user-app port. It answers the wr/rd commands issued by dflow_generator_core on qdr_clk.
- Holds an on-chip RAM image, emulates calibration delay, and returns read data after a fixed, parameterized latency.
- Used in simulation and in board bring-up builds without QDR; it drops into the same user_app_* net names.

Parameters:
- QDR_ADDR_WIDTH, 19, width of command addresses.
- QDR_DATA_WIDTH_TOTAL, 144, width of write/read data words.
- MEM_ADDR_BITS, 10, implemented RAM depth = 2**MEM_ADDR_BITS words.
- RD_LATENCY, 8, cycles from rd_cmd sample to rd_valid; legal range 2..32.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises; legal range 1..65535.

Ports:
- qdr_clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- init_calib_complete  out  1  calibration-done emulation.
- user_app_wr_cmd  in  1  write command strobe.
- user_app_wr_addr  in  19  write address.
- user_app_wr_data  in  144  write data.
- user_app_rd_cmd  in  1  read command strobe.
- user_app_rd_addr  in  19  read address.
- user_app_rd_valid  out  1  read data valid, one cycle per read.
- user_app_rd_data  out  144  read data.
- wr_cnt  out  32  accepted writes, saturating.
- rd_cnt  out  32  accepted reads, saturating.
- early_cmd_err  out  1  sticky: a command arrived while calib was low.
- oob_err  out  1  sticky: an accepted address had bits above MEM_ADDR_BITS-1 set.

Behaviour:
- Reset: all outputs 0. Calib counter = 0. Read pipeline valid bits cleared. RAM contents are not cleared.
- Calibration:
  - State CALIB counts qdr_clk cycles after resetn is high.
  - When the count reaches CALIB_CYCLES, init_calib_complete goes to 1 on the next edge and the block enters READY.
  - READY holds until reset.
- Command acceptance:
  - A command is accepted only when its strobe is 1 on an edge in READY. There is no ready/backpressure; the block accepts one wr and one rd per cycle, simultaneously if both strobes are high.
  - A command in CALIB is discarded, not counted, and sets early_cmd_err.
- Write: RAM[wr_addr[MEM_ADDR_BITS-1:0]] <= wr_data on the accept edge. wr_cnt increments.
- Read:
  - RAM is read at rd_addr[MEM_ADDR_BITS-1:0] on the accept edge, then delayed through a shift pipeline.
  - user_app_rd_valid = 1 and rd_data are presented exactly RD_LATENCY edges after the accept edge. rd_cnt increments at accept.
  - Back-to-back reads on every cycle produce back-to-back valids in order.
  - rd_data is 0 whenever rd_valid = 0.
- Same-cycle rd and wr to the same RAM address: the read returns the old data (read-before-write).
- Address above range: the address is truncated (aliases) and oob_err is set. Applies to both wr and rd.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Reset mid-operation:
  - rd_valid is 0 from the first cycle after the reset edge. In-flight reads are dropped.
  - Calibration restarts from 0. The sticky errors clear.
- The RAM maps to block RAM; the output pipeline is registered. There is no combinational path from inputs to outputs.

Test Plan:
- Calibration timing: release resetn at cycle 0 with CALIB_CYCLES=64. init_calib_complete must be 0 through cycle 64 and 1 from cycle 65. A wr_cmd at cycle 10 must set early_cmd_err=1, leave wr_cnt=0, and leave RAM unchanged.
- Write then read, RD_LATENCY=8:
  - Write addr 0x005 with 144'hA5..A5 at cycle T, then read addr 0x005 at T+1.
  - Required: rd_valid=1 only at cycle T+9 with rd_data=144'hA5..A5; wr_cnt=1, rd_cnt=1.
- Streaming:
  - Write addrs 0..15 with data=addr, then issue 16 consecutive reads of addrs 0..15.
  - Required: 16 consecutive rd_valid cycles with data 0..15 in order and no gaps.
- Simultaneous rd/wr at addr 0x020:
  - The location holds 1; on the same cycle, write 2 and read.
  - Required: the read returns 1. A read on the following cycle returns 2.
- Out of range: write addr 19'h40003 with data 7, then read addr 0x003. Required: data 7 is returned and oob_err=1.
- Reset mid-flight: issue 4 reads, then assert resetn=0 for 1 cycle, 3 cycles later. Required: no rd_valid after the reset edge, init_calib_complete=0, and counters and errors back to 0.

Source files
------------

// File: rtl/qdr_user_app_responder.sv
// ============================================================================
// qdr_user_app_responder : on-chip RAM stand-in for the QDR MIG user-app port
// Rev 1.0
// ============================================================================
`default_nettype none

module qdr_user_app_responder #(
  parameter int QDR_ADDR_WIDTH       = 19,
  parameter int QDR_DATA_WIDTH_TOTAL = 144,
  parameter int MEM_ADDR_BITS        = 10,
  parameter int RD_LATENCY           = 8,
  parameter int CALIB_CYCLES         = 64
) (
  input  logic                            qdr_clk,
  input  logic                            resetn,
  output logic                            o_init_calib_complete,
  input  logic                            i_user_app_wr_cmd,
  input  logic [QDR_ADDR_WIDTH-1:0]       i_user_app_wr_addr,
  input  logic [QDR_DATA_WIDTH_TOTAL-1:0] i_user_app_wr_data,
  input  logic                            i_user_app_rd_cmd,
  input  logic [QDR_ADDR_WIDTH-1:0]       i_user_app_rd_addr,
  output logic                            o_user_app_rd_valid,
  output logic [QDR_DATA_WIDTH_TOTAL-1:0] o_user_app_rd_data,
  output logic [31:0]                     o_wr_cnt,
  output logic [31:0]                     o_rd_cnt,
  output logic                            o_early_cmd_err,
  output logic                            o_oob_err
);

  localparam logic [15:0] c_calib_cycles = 16'(CALIB_CYCLES);

  typedef enum logic [0:0] {
    S_CALIB = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_ready;

  logic [15:0] r_calib_cnt;

  logic [QDR_DATA_WIDTH_TOTAL-1:0] r_ram [2**MEM_ADDR_BITS];
  logic [QDR_DATA_WIDTH_TOTAL-1:0] r_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0]           r_vld;
  logic [QDR_DATA_WIDTH_TOTAL-1:0] r_rd_data;
  logic                            r_rd_valid;
  logic [31:0]                     r_wr_cnt;
  logic [31:0]                     r_rd_cnt;
  logic                            r_early_cmd_err;
  logic                            r_oob_err;

  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_early;
  logic                     w_wr_oob;
  logic                     w_rd_oob;
  logic [MEM_ADDR_BITS-1:0] w_wr_idx;
  logic [MEM_ADDR_BITS-1:0] w_rd_idx;

  always_ff @(posedge qdr_clk) begin
    if (!resetn) r_state <= S_CALIB;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_CALIB: if (r_calib_cnt == c_calib_cycles) w_state_nxt = S_READY;
      S_READY: w_ready = 1'b1;
      default: w_state_nxt = S_CALIB;
    endcase
  end

  // The counter parks at CALIB_CYCLES; the following edge moves to READY.
  always_ff @(posedge qdr_clk) begin
    if (!resetn)
      r_calib_cnt <= '0;
    else if (r_state == S_CALIB && r_calib_cnt != c_calib_cycles)
      r_calib_cnt <= r_calib_cnt + 16'd1;
  end

  assign w_wr_acc = w_ready & i_user_app_wr_cmd;
  assign w_rd_acc = w_ready & i_user_app_rd_cmd;
  assign w_early  = ~w_ready & (i_user_app_wr_cmd | i_user_app_rd_cmd);
  assign w_wr_oob = |(i_user_app_wr_addr >> MEM_ADDR_BITS);
  assign w_rd_oob = |(i_user_app_rd_addr >> MEM_ADDR_BITS);
  assign w_wr_idx = i_user_app_wr_addr[MEM_ADDR_BITS-1:0];
  assign w_rd_idx = i_user_app_rd_addr[MEM_ADDR_BITS-1:0];

  // RAM image survives reset so contents persist across re-calibration.
  always_ff @(posedge qdr_clk) begin
    if (resetn && w_wr_acc) r_ram[w_wr_idx] <= i_user_app_wr_data;
  end

  // Data stages carry no reset; the valid chain qualifies them.
  always_ff @(posedge qdr_clk) begin
    if (w_rd_acc) r_dat[0] <= r_ram[w_rd_idx];
    for (int i = 1; i < RD_LATENCY; i++) r_dat[i] <= r_dat[i-1];
  end

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      r_vld      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_vld      <= {r_vld[RD_LATENCY-2:0], w_rd_acc};
      r_rd_valid <= r_vld[RD_LATENCY-1];
      r_rd_data  <= r_vld[RD_LATENCY-1] ? r_dat[RD_LATENCY-1] : '0;
    end
  end

  always_ff @(posedge qdr_clk) begin
    if (!resetn) begin
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_early_cmd_err <= 1'b0;
      r_oob_err       <= 1'b0;
    end else begin
      if (w_wr_acc && r_wr_cnt != 32'hFFFF_FFFF) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (w_rd_acc && r_rd_cnt != 32'hFFFF_FFFF) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_early) r_early_cmd_err <= 1'b1;
      if ((w_wr_acc && w_wr_oob) || (w_rd_acc && w_rd_oob)) r_oob_err <= 1'b1;
    end
  end

  assign o_init_calib_complete = (r_state == S_READY);
  assign o_user_app_rd_valid   = r_rd_valid;
  assign o_user_app_rd_data    = r_rd_data;
  assign o_wr_cnt              = r_wr_cnt;
  assign o_rd_cnt              = r_rd_cnt;
  assign o_early_cmd_err       = r_early_cmd_err;
  assign o_oob_err             = r_oob_err;

endmodule

`default_nettype wire
